// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and access-size helper.
`timescale 1ns/1ps
package mem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  // Low two funct3 bits encode log2 of the access size for every legal code.
  function automatic logic [1:0] f3_size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus port bundle between the LSU (master) and the data memory (slave):
// req/gnt request phase followed by an rvalid read-data phase.
`timescale 1ns/1ps
interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store byte-enables/replicated data/fault check,
// and load lane selection with sign or zero extension.
`timescale 1ns/1ps
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_ea,
  input  logic [31:0] i_rs2,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_fault,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_ea,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_legal;
  logic        w_misalign;
  logic [31:0] w_shifted;

  always_comb begin
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    o_be       = 4'b1111;
    o_wdata    = i_rs2;
    if (i_is_load)
      w_legal = i_st_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else if (i_is_store)
      w_legal = i_st_funct3 inside {F3_SB, F3_SH, F3_SW};
    case (f3_size_log2(i_st_funct3))
      2'd0: begin
        o_be    = 4'b0001 << i_st_ea;
        o_wdata = {4{i_rs2[7:0]}};
      end
      2'd1: begin
        w_misalign = i_st_ea[0];
        o_be       = i_st_ea[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_rs2[15:0]}};
      end
      default: w_misalign = (i_st_ea != 2'b00);
    endcase
    o_fault = (i_is_load || i_is_store) && (!w_legal || w_misalign);
  end

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  assign w_shifted = i_rdata >> {i_ld_ea, 3'b000};

  always_comb begin
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_ld_data = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_ld_data = {16'd0, w_shifted[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts EX results, runs data-bus accesses and
// registers the WB-bound result (the MEM/WB pipeline register lives here).
`timescale 1ns/1ps
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [31:0]       rd_data_i,
  input  logic [31:0]       rs2_data_i,
  input  logic              flush_i,
  mem_lsu_if.master         bus,
  output logic              wb_valid,
  output logic              wb_rd_we,
  output logic [4:0]        wb_rd_addr,
  output logic [31:0]       wb_rd_data,
  output logic              lsu_fault
);

  lsu_state_e            r_state;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [1:0]            r_ea_lo;
  logic                  r_rd_we;
  logic [4:0]            r_rd_addr;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_be;
  logic [31:0]           r_bus_wdata;
  logic                  r_wb_valid;
  logic                  r_wb_rd_we;
  logic [4:0]            r_wb_rd_addr;
  logic [31:0]           r_wb_rd_data;
  logic                  r_lsu_fault;

  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_fault;
  logic [31:0]           w_ld_data;
  logic                  w_is_mem;

  mem_lsu_align u_align (
    .i_is_load   (is_load_i),
    .i_is_store  (is_store_i),
    .i_st_funct3 (funct3_i),
    .i_st_ea     (rd_data_i[1:0]),
    .i_rs2       (rs2_data_i),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_fault     (w_fault),
    .i_ld_funct3 (r_funct3),
    .i_ld_ea     (r_ea_lo),
    .i_rdata     (bus.bus_rdata),
    .o_ld_data   (w_ld_data)
  );

  assign w_is_mem = is_load_i || is_store_i;
  assign in_ready = (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_ea_lo      <= 2'd0;
      r_rd_we      <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= 4'd0;
      r_bus_wdata  <= 32'd0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_we   <= 1'b0;
      r_wb_rd_addr <= 5'd0;
      r_wb_rd_data <= 32'd0;
      r_lsu_fault  <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_lsu_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !flush_i) begin
            if (!w_is_mem) begin
              r_wb_valid   <= 1'b1;
              r_wb_rd_we   <= rd_we_i;
              r_wb_rd_addr <= rd_addr_i;
              r_wb_rd_data <= rd_data_i;
            end else if (w_fault) begin
              r_wb_valid   <= 1'b1;
              r_wb_rd_we   <= 1'b0;
              r_wb_rd_addr <= rd_addr_i;
              r_wb_rd_data <= 32'd0;
              r_lsu_fault  <= 1'b1;
            end else begin
              r_is_load   <= is_load_i;
              r_funct3    <= funct3_i;
              r_ea_lo     <= rd_data_i[1:0];
              r_rd_we     <= rd_we_i;
              r_rd_addr   <= rd_addr_i;
              r_bus_req   <= 1'b1;
              r_bus_we    <= is_store_i;
              r_bus_addr  <= {rd_data_i[ADDR_WIDTH-1:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            r_bus_req <= 1'b0;
            if (r_is_load) begin
              r_state <= flush_i ? ST_DRAIN : ST_RESP;
            end else begin
              r_state <= ST_IDLE;
              if (!flush_i) begin
                r_wb_valid   <= 1'b1;
                r_wb_rd_we   <= 1'b0;
                r_wb_rd_addr <= r_rd_addr;
                r_wb_rd_data <= 32'd0;
              end
            end
          end else if (flush_i) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          // A flush coinciding with rvalid has nothing left to drain.
          if (flush_i) begin
            r_state <= bus.bus_rvalid ? ST_IDLE : ST_DRAIN;
          end else if (bus.bus_rvalid) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd_we   <= r_rd_we && (r_rd_addr != 5'd0);
            r_wb_rd_addr <= r_rd_addr;
            r_wb_rd_data <= w_ld_data;
            r_state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (bus.bus_rvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;
  assign wb_valid      = r_wb_valid;
  assign wb_rd_we      = r_wb_rd_we;
  assign wb_rd_addr    = r_wb_rd_addr;
  assign wb_rd_data    = r_wb_rd_data;
  assign lsu_fault     = r_lsu_fault;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized bench for mem_lsu against a byte-addressed memory
// reference model; one line per transaction, one summary line.
`timescale 1ns/1ps
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_load_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic        rd_we_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic [31:0] rd_data_i = 32'd0;
  logic [31:0] rs2_data_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        wb_valid;
  logic        wb_rd_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        lsu_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0] bmem [int];

  mem_lsu_if #(.ADDR_WIDTH(32)) bus_if ();

  mem_lsu #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_load_i  (is_load_i),
    .is_store_i (is_store_i),
    .funct3_i   (funct3_i),
    .rd_we_i    (rd_we_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .bus        (bus_if.master),
    .wb_valid   (wb_valid),
    .wb_rd_we   (wb_rd_we),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data),
    .lsu_fault  (lsu_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rd_byte(input int a);
    if (bmem.exists(a)) return bmem[a];
    return 8'(a * 37 + 11);
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_fault(input bit ld, input logic [2:0] f3, input logic [31:0] ea);
    bit legal;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    if (!legal) return 1'b1;
    return (ea % nbytes(f3)) != 0;
  endfunction

  task automatic nonmem(input logic [4:0] rd, input logic [31:0] data, input bit we);
    in_valid = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0;
    rd_we_i = we; rd_addr_i = rd; rd_data_i = data;
    check("alu_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_wb_addr", 32'(wb_rd_addr), 32'(rd));
    check("alu_wb_data", wb_rd_data, data);
    check("alu_wb_we", 32'(wb_rd_we), 32'(we));
    check("alu_fault", 32'(lsu_fault), 32'd0);
    $display("alu  rd=x%0d data=%h we=%0d", rd, data, we);
  endtask

  task automatic mem_op(input bit ld, input logic [2:0] f3, input bit we, input logic [4:0] rd,
                        input logic [31:0] ea, input logic [31:0] rs2, input int gdly, input int rdly);
    int n;
    int off;
    int held;
    bit flt;
    logic [31:0] mask;
    logic [31:0] exp_v;
    logic [31:0] word;
    n   = nbytes(f3);
    off = int'(ea % 4);
    flt = ref_fault(ld, f3, ea);
    in_valid = 1'b1; is_load_i = ld; is_store_i = !ld; funct3_i = f3;
    rd_we_i = we; rd_addr_i = rd; rd_data_i = ea; rs2_data_i = rs2;
    check("mem_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    if (flt) begin
      check("flt_wb_valid", 32'(wb_valid), 32'd1);
      check("flt_fault", 32'(lsu_fault), 32'd1);
      check("flt_wb_we", 32'(wb_rd_we), 32'd0);
      check("flt_bus_req", 32'(bus_if.bus_req), 32'd0);
      check("flt_in_ready", 32'(in_ready), 32'd1);
      $display("%s f3=%0d ea=%h -> fault", ld ? "load " : "store", f3, ea);
      return;
    end
    check("mem_wb_idle", 32'(wb_valid), 32'd0);
    check("mem_addr", bus_if.bus_addr, ea - 32'(off));
    check("mem_we", 32'(bus_if.bus_we), 32'(!ld));
    check("mem_be", 32'(bus_if.bus_be), ((32'd1 << n) - 32'd1) << off);
    if (!ld) begin
      if (n == 1)      exp_v = 32'(rs2[7:0]) * 32'h01010101;
      else if (n == 2) exp_v = 32'(rs2[15:0]) * 32'h00010001;
      else             exp_v = rs2;
      check("mem_wdata", bus_if.bus_wdata, exp_v);
    end
    held = 0;
    for (int i = 0; i <= gdly; i++) begin
      if (bus_if.bus_req === 1'b1) held++;
      if (i == gdly) bus_if.bus_gnt = 1'b1;
      step();
    end
    bus_if.bus_gnt = 1'b0;
    check("mem_req_held", 32'(held), 32'(gdly + 1));
    check("mem_req_drop", 32'(bus_if.bus_req), 32'd0);
    if (!ld) begin
      for (int i = 0; i < n; i++) bmem[int'(ea) + i] = rs2[8*i +: 8];
      check("st_wb_valid", 32'(wb_valid), 32'd1);
      check("st_wb_we", 32'(wb_rd_we), 32'd0);
      check("st_fault", 32'(lsu_fault), 32'd0);
      $display("store f3=%0d ea=%h rs2=%h gnt_dly=%0d", f3, ea, rs2, gdly);
    end else begin
      check("ld_wb_early", 32'(wb_valid), 32'd0);
      for (int i = 0; i < rdly; i++) step();
      word = 32'd0;
      for (int i = 0; i < 4; i++) word[8*i +: 8] = rd_byte(int'(ea) - off + i);
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = word;
      step();
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = 32'hDEADBEEF;
      exp_v = 32'd0;
      for (int i = 0; i < n; i++) exp_v[8*i +: 8] = rd_byte(int'(ea) + i);
      mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 32'd1);
      if (f3[2] == 1'b0 && n < 4 && exp_v[8*n-1]) exp_v = exp_v | ~mask;
      check("ld_wb_valid", 32'(wb_valid), 32'd1);
      check("ld_wb_data", wb_rd_data, exp_v);
      check("ld_wb_we", 32'(wb_rd_we), 32'(we && rd != 5'd0));
      check("ld_wb_addr", 32'(wb_rd_addr), 32'(rd));
      $display("load  f3=%0d ea=%h rd=x%0d -> %h", f3, ea, rd, exp_v);
    end
    check("mem_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'd0;
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_fault", 32'(lsu_fault), 32'd0);
    check("rst_wb_data", wb_rd_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // 1: back-to-back non-memory ops
    nonmem(5'd5, 32'd1, 1'b1);
    nonmem(5'd6, 32'd2, 1'b1);
    nonmem(5'd7, 32'd3, 1'b1);
    step();
    check("alu_pulse_end", 32'(wb_valid), 32'd0);

    // 2: byte store on the top lane, grant after two wait cycles
    mem_op(1'b0, 3'b000, 1'b0, 5'd0, 32'h1003, 32'h000000A5, 2, 0);

    // 3: load lane selection and extension
    bmem[32'h2000] = 8'h00; bmem[32'h2001] = 8'hFF; bmem[32'h2002] = 8'h80; bmem[32'h2003] = 8'h00;
    mem_op(1'b1, 3'b000, 1'b1, 5'd10, 32'h2002, 32'd0, 0, 1);
    mem_op(1'b1, 3'b001, 1'b1, 5'd11, 32'h2002, 32'd0, 1, 0);
    bmem[32'h2002] = 8'h00;
    mem_op(1'b1, 3'b100, 1'b1, 5'd12, 32'h2001, 32'd0, 0, 0);
    mem_op(1'b1, 3'b000, 1'b1, 5'd13, 32'h2001, 32'd0, 0, 2);
    mem_op(1'b1, 3'b010, 1'b1, 5'd0, 32'h2000, 32'd0, 0, 0);

    // 4: faults
    mem_op(1'b1, 3'b010, 1'b1, 5'd14, 32'h3002, 32'd0, 0, 0);
    mem_op(1'b1, 3'b011, 1'b1, 5'd15, 32'h3000, 32'd0, 0, 0);
    mem_op(1'b0, 3'b100, 1'b0, 5'd0, 32'h3000, 32'h1234, 0, 0);
    mem_op(1'b0, 3'b001, 1'b0, 5'd0, 32'h3001, 32'h1234, 0, 0);

    // 5: flush while waiting for read data
    in_valid = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; rd_we_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h2000;
    step();
    in_valid = 1'b0; is_load_i = 1'b0;
    bus_if.bus_gnt = 1'b1; step(); bus_if.bus_gnt = 1'b0;
    flush_i = 1'b1;
    check("fl_resp_busy", 32'(in_ready), 32'd0);
    step(); flush_i = 1'b0;
    check("fl_resp_wb", 32'(wb_valid), 32'd0);
    check("fl_drain_busy", 32'(in_ready), 32'd0);
    step();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h11223344;
    step(); bus_if.bus_rvalid = 1'b0;
    check("fl_drain_wb", 32'(wb_valid), 32'd0);
    check("fl_drain_ready", 32'(in_ready), 32'd1);
    $display("flush in RESP, drained");

    // flush in IDLE, in REQ without grant, and coincident with grant
    in_valid = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h55; flush_i = 1'b1;
    step(); in_valid = 1'b0; flush_i = 1'b0;
    check("fl_idle_wb", 32'(wb_valid), 32'd0);
    in_valid = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; rd_data_i = 32'h5000;
    step(); in_valid = 1'b0; is_store_i = 1'b0;
    check("fl_req_up", 32'(bus_if.bus_req), 32'd1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("fl_req_drop", 32'(bus_if.bus_req), 32'd0);
    check("fl_req_wb", 32'(wb_valid), 32'd0);
    check("fl_req_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; is_store_i = 1'b1; funct3_i = 3'b000; rd_data_i = 32'h6001;
    step(); in_valid = 1'b0; is_store_i = 1'b0;
    bus_if.bus_gnt = 1'b1; flush_i = 1'b1; step(); bus_if.bus_gnt = 1'b0; flush_i = 1'b0;
    check("fl_stgnt_wb", 32'(wb_valid), 32'd0);
    check("fl_stgnt_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; rd_data_i = 32'h6000;
    step(); in_valid = 1'b0; is_load_i = 1'b0;
    bus_if.bus_gnt = 1'b1; flush_i = 1'b1; step(); bus_if.bus_gnt = 1'b0; flush_i = 1'b0;
    check("fl_ldgnt_busy", 32'(in_ready), 32'd0);
    bus_if.bus_rvalid = 1'b1; step(); bus_if.bus_rvalid = 1'b0;
    check("fl_ldgnt_wb", 32'(wb_valid), 32'd0);
    check("fl_ldgnt_ready", 32'(in_ready), 32'd1);
    $display("flush in IDLE/REQ/REQ+gnt handled");

    // 6: asynchronous reset in the middle of a request
    in_valid = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; rd_data_i = 32'h7000; rs2_data_i = 32'hCAFEF00D;
    step(); in_valid = 1'b0; is_store_i = 1'b0;
    check("rs_req_up", 32'(bus_if.bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_req_async", 32'(bus_if.bus_req), 32'd0);
    check("rs_wb_valid", 32'(wb_valid), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    step();
    bus_if.bus_rvalid = 1'b1; step(); bus_if.bus_rvalid = 1'b0;
    check("rs_stray_rvalid", 32'(wb_valid), 32'd0);
    $display("reset during REQ recovered");
    mem_op(1'b0, 3'b001, 1'b0, 5'd0, 32'h7002, 32'h0000BEEF, 1, 0);
    mem_op(1'b1, 3'b101, 1'b1, 5'd20, 32'h7002, 32'd0, 0, 1);

    // randomized mix against the byte-memory model
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0)
        nonmem(5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)));
      else
        mem_op(kind == 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               32'h4000 + 32'($urandom_range(0, 15)), $urandom,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
